// File: rtl/weight_stream_scheduler.sv
// Weight-fetch sequencer for a 3-layer MLP: walks a flat weight memory node by node
// as the datapath requests layers and retires nodes.
module weight_stream_scheduler #(
    parameter int DATA_WIDTH                    = 32,
    parameter int NUMBER_OF_INPUT_NODE          = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int ADDR_WIDTH                    = $clog2(
        NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1) +
        NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1) +
        NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_layer_req,
    input  logic [1:0]            i_layer,
    input  logic                  i_node_done,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [DATA_WIDTH-1:0] o_weight,
    output logic                  o_weight_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int F1 = NUMBER_OF_INPUT_NODE;
    localparam int F2 = NUMBER_OF_HIDDEN_NODE_LAYER_1;
    localparam int F3 = NUMBER_OF_HIDDEN_NODE_LAYER_2;
    localparam int B2 = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (F1 + 1);
    localparam int B3 = B2 + NUMBER_OF_HIDDEN_NODE_LAYER_2 * (F2 + 1);

    typedef enum logic [2:0] {IDLE, WAIT_LAYER, ISSUE, WAIT_NODE, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            layer_q, layer_d;
    logic [ADDR_WIDTH-1:0] node_q, node_d;
    logic [ADDR_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  error_q, error_d;
    logic                  valid_q, valid_d;
    logic                  rd_en;

    logic [ADDR_WIDTH-1:0] fan_k, last_k, base_k;

    always_comb begin
        case (layer_q)
            2'd1: begin
                fan_k  = ADDR_WIDTH'(F1);
                last_k = ADDR_WIDTH'(NUMBER_OF_HIDDEN_NODE_LAYER_1 - 1);
                base_k = '0;
            end
            2'd2: begin
                fan_k  = ADDR_WIDTH'(F2);
                last_k = ADDR_WIDTH'(NUMBER_OF_HIDDEN_NODE_LAYER_2 - 1);
                base_k = ADDR_WIDTH'(B2);
            end
            default: begin
                fan_k  = ADDR_WIDTH'(F3);
                last_k = ADDR_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);
                base_k = ADDR_WIDTH'(B3);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            layer_q <= '0;
            node_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            node_q  <= node_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            error_q <= error_d;
            valid_q <= valid_d;
        end
    end

    // Nodes and layers are packed back to back, so the address simply keeps
    // counting across node boundaries; it is re-seeded from the layer base on entry.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        node_d  = node_q;
        word_d  = word_q;
        addr_d  = addr_q;
        error_d = error_q;
        if (i_abort) begin
            state_d = IDLE;
            layer_d = '0;
            node_d  = '0;
            word_d  = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    state_d = WAIT_LAYER;
                    layer_d = 2'd1;
                    node_d  = '0;
                    word_d  = '0;
                    addr_d  = '0;
                    error_d = 1'b0;
                end
                WAIT_LAYER: if (i_layer_req) begin
                    node_d = '0;
                    word_d = '0;
                    if (i_layer == layer_q) begin
                        state_d = ISSUE;
                        addr_d  = base_k;
                    end else begin
                        state_d = IDLE;
                        error_d = 1'b1;
                        layer_d = '0;
                        addr_d  = '0;
                    end
                end
                ISSUE: begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (word_q == fan_k) begin
                        word_d  = '0;
                        state_d = WAIT_NODE;
                    end else begin
                        word_d = word_q + ADDR_WIDTH'(1);
                    end
                end
                WAIT_NODE: if (i_node_done) begin
                    node_d = node_q + ADDR_WIDTH'(1);
                    word_d = '0;
                    if (node_q != last_k) begin
                        state_d = ISSUE;
                    end else if (layer_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        layer_d = layer_q + 2'd1;
                        state_d = WAIT_LAYER;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    layer_d = '0;
                    node_d  = '0;
                    word_d  = '0;
                    addr_d  = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Abort gates both the strobe and the returning beat combinationally.
    always_comb begin
        rd_en          = (state_q == ISSUE) && !i_abort;
        valid_d        = rd_en;
        o_mem_rd_en    = rd_en;
        o_mem_addr     = addr_q;
        o_weight_valid = valid_q && !i_abort;
        o_weight       = o_weight_valid ? i_mem_data : '0;
        o_busy         = (state_q != IDLE);
        o_done         = (state_q == DONE);
        o_error        = error_q;
    end

endmodule

// File: tb/tb_weight_stream_scheduler.sv
// Directed bench for weight_stream_scheduler: scoreboard of expected read addresses
// and weight beats, plus framing, abort, sequence-error and reset scenarios.
module tb_weight_stream_scheduler;

    localparam int DW = 32;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start, i_abort, i_layer_req, i_node_done;
    logic [1:0]    i_layer;
    logic          o_mem_rd_en;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] i_mem_data, o_weight;
    logic          o_weight_valid, o_busy, o_done, o_error;

    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;
    int          exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] mem_q = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    weight_stream_scheduler #(
        .DATA_WIDTH(32),
        .NUMBER_OF_INPUT_NODE(2),
        .NUMBER_OF_HIDDEN_NODE_LAYER_1(32),
        .NUMBER_OF_HIDDEN_NODE_LAYER_2(32),
        .NUMBER_OF_OUTPUT_NODE(3)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_layer_req(i_layer_req), .i_layer(i_layer), .i_node_done(i_node_done),
        .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_weight(o_weight), .o_weight_valid(o_weight_valid), .o_busy(o_busy),
        .o_done(o_done), .o_error(o_error)
    );

    function automatic logic [31:0] wgt(input int a);
        return 32'h3F80_0000 ^ (32'(a) * 32'h0001_9E37);
    endfunction

    function automatic int fanin(input int l);
        return (l == 1) ? 2 : 32;
    endfunction

    function automatic int nodes(input int l);
        return (l == 3) ? 3 : 32;
    endfunction

    function automatic int lbase(input int l);
        return (l == 1) ? 0 : (l == 2) ? 96 : 1152;
    endfunction

    // Weight memory with one-cycle read latency.
    always @(posedge clk) if (o_mem_rd_en) mem_q <= wgt(int'(o_mem_addr));
    assign i_mem_data = mem_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_mem_rd_en) begin
                if (exp_addr_q.size() == 0) chk("unexpected_read", 64'(o_mem_rd_en), 64'(0));
                else chk("rd_addr", 64'(o_mem_addr), 64'(exp_addr_q.pop_front()));
            end
            if (o_weight_valid) begin
                beat_cnt++;
                if (exp_data_q.size() == 0) chk("unexpected_beat", 64'(o_weight_valid), 64'(0));
                else chk("weight", 64'(o_weight), 64'(exp_data_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic send_node_done();
        step();
        i_node_done = 1'b1;
        step();
        i_node_done = 1'b0;
    endtask

    // Triggers one node (layer request for node 0, node_done otherwise) and checks framing.
    task automatic run_node(input int l, input int n);
        int fan = fanin(l);
        int a0  = lbase(l) + n * (fan + 1);
        step();
        for (int w = 0; w <= fan; w++) begin
            exp_addr_q.push_back(a0 + w);
            exp_data_q.push_back(wgt(a0 + w));
        end
        if (n == 0) begin
            i_layer_req = 1'b1;
            i_layer     = 2'(l);
        end else begin
            i_node_done = 1'b1;
        end
        step();
        i_layer_req = 1'b0;
        i_node_done = 1'b0;
        for (int i = 0; i <= fan + 2; i++) begin
            @(negedge clk);
            chk("rd_frame", 64'(o_mem_rd_en), 64'(i <= fan));
            if (i == 0 && n == 0) chk("layer_first_addr", 64'(o_mem_addr), 64'(lbase(l)));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, 64'(o_mem_rd_en), 64'(0));
        chk({tag, "_valid"}, 64'(o_weight_valid), 64'(0));
        chk({tag, "_busy"},  64'(o_busy), 64'(0));
        chk({tag, "_done"},  64'(o_done), 64'(0));
        chk({tag, "_error"}, 64'(o_error), 64'(0));
        chk({tag, "_addr"},  64'(o_mem_addr), 64'(0));
        chk({tag, "_weight"}, 64'(o_weight), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no end of test, required finish before 2ms");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_layer_req = 1'b0; i_node_done = 1'b0; i_layer = 2'd0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        step();
        rst = 1'b0;

        // Sequence error: layer 2 requested while layer 1 expected.
        step(); i_start = 1'b1;
        step(); i_start = 1'b0; i_layer_req = 1'b1; i_layer = 2'd2;
        step(); i_layer_req = 1'b0; i_layer = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("seqerr_error", 64'(o_error), 64'(1));
            chk("seqerr_busy", 64'(o_busy), 64'(0));
            chk("seqerr_rd_en", 64'(o_mem_rd_en), 64'(0));
        end
        step(); i_start = 1'b1;
        step(); i_start = 1'b0;
        @(negedge clk);
        chk("restart_error_clear", 64'(o_error), 64'(0));
        chk("restart_busy", 64'(o_busy), 64'(1));

        // Full pass; a stray i_start in WAIT_NODE and in DONE must be ignored.
        beat_cnt = 0;
        for (int l = 1; l <= 3; l++) begin
            for (int n = 0; n < nodes(l); n++) begin
                if (l == 2 && n == 3) begin
                    step(); i_start = 1'b1;
                    step(); i_start = 1'b0;
                end
                run_node(l, n);
            end
            send_node_done();
        end
        i_start = 1'b1;
        @(negedge clk);
        chk("done_pulse", 64'(o_done), 64'(1));
        chk("done_busy", 64'(o_busy), 64'(1));
        step(); i_start = 1'b0;
        @(negedge clk);
        chk("done_clear", 64'(o_done), 64'(0));
        chk("idle_busy", 64'(o_busy), 64'(0));
        chk("beat_count", 64'(beat_cnt), 64'(1251));
        chk("sb_addr_empty", 64'(exp_addr_q.size()), 64'(0));
        chk("sb_data_empty", 64'(exp_data_q.size()), 64'(0));

        // Abort beats a simultaneous start.
        step(); i_abort = 1'b1; i_start = 1'b1;
        step(); i_abort = 1'b0; i_start = 1'b0;
        @(negedge clk);
        chk("abort_prio_busy", 64'(o_busy), 64'(0));

        // Abort the cycle after the read of address 50 (layer 1, node 16, bias word).
        step(); i_start = 1'b1;
        step(); i_start = 1'b0;
        for (int n = 0; n < 16; n++) run_node(1, n);
        step();
        for (int w = 48; w <= 50; w++) begin
            exp_addr_q.push_back(w);
            exp_data_q.push_back(wgt(w));
        end
        i_node_done = 1'b1;
        step(); i_node_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_rd50_en", 64'(o_mem_rd_en), 64'(1));
        chk("abort_rd50_addr", 64'(o_mem_addr), 64'(50));
        step(); i_abort = 1'b1;
        @(negedge clk);
        chk("abort_valid_suppressed", 64'(o_weight_valid), 64'(0));
        step(); i_abort = 1'b0;
        flush();
        @(negedge clk);
        chk("abort_busy", 64'(o_busy), 64'(0));
        chk("abort_rd_en", 64'(o_mem_rd_en), 64'(0));
        step(); i_start = 1'b1;
        step(); i_start = 1'b0;
        run_node(1, 0);
        step(); i_abort = 1'b1;
        step(); i_abort = 1'b0;
        @(negedge clk);
        chk("abort2_busy", 64'(o_busy), 64'(0));

        // Asynchronous reset while issuing reads.
        step(); i_start = 1'b1;
        step(); i_start = 1'b0;
        step();
        for (int w = 0; w <= 2; w++) begin
            exp_addr_q.push_back(w);
            exp_data_q.push_back(wgt(w));
        end
        i_layer_req = 1'b1; i_layer = 2'd1;
        step(); i_layer_req = 1'b0;
        #1;
        chk("pre_reset_rd_en", 64'(o_mem_rd_en), 64'(1));
        #1 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        flush();
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_valid", 64'(o_weight_valid), 64'(0));
            chk("post_reset_busy", 64'(o_busy), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_stream_scheduler.md
WEIGHT_STREAM_SCHEDULER -- requirements
Module: weight_stream_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 32, IEEE-754 single word width.
- NUMBER_OF_INPUT_NODE, 2, fan-in of hidden layer 1.
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, node count of hidden layer 1.
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, node count of hidden layer 2.
- NUMBER_OF_OUTPUT_NODE, 3, node count of the output layer.
- ADDR_WIDTH, derived, $clog2 of the total weight words (11 at defaults).
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- i_start, in, 1, pulse that begins one forward pass.
- i_abort, in, 1, synchronous cancel of the current pass.
- i_layer_req, in, 1, datapath ready for a layer's weights.
- i_layer, in, 2, layer the datapath is requesting (1, 2 or 3).
- i_node_done, in, 1, datapath finished one node.
- o_mem_rd_en, out, 1, weight memory read strobe.
- o_mem_addr, out, ADDR_WIDTH, weight memory word address.
- i_mem_data, in, DATA_WIDTH, read data, valid 1 cycle after o_mem_rd_en.
- o_weight, out, DATA_WIDTH, weight word to the datapath.
- o_weight_valid, out, 1, o_weight is valid.
- o_busy, out, 1, a pass is in progress.
- o_done, out, 1, one-cycle pulse when a pass completes.
- o_error, out, 1, sticky layer-sequence error.

Function
REQ-004 Fan-in per layer SHALL be F1=NUMBER_OF_INPUT_NODE, F2=NUMBER_OF_HIDDEN_NODE_LAYER_1, F3=NUMBER_OF_HIDDEN_NODE_LAYER_2; each node SHALL consume F+1 words (weights, then bias).
REQ-005 Layer base addresses SHALL be B1=0, B2=H1*(F1+1), B3=B2+H2*(F2+1); at defaults these are 0, 96 and 1152, with 1251 words in total.
REQ-006 The word address SHALL be Bk + node*(Fk+1) + word, formed with counters and incremental adds only, without multipliers.
REQ-007 The FSM SHALL have the states IDLE, WAIT_LAYER, ISSUE, WAIT_NODE and DONE.
REQ-008 In IDLE, i_start SHALL move the FSM to WAIT_LAYER with expected layer=1; i_start in any other state SHALL be ignored.
REQ-009 In WAIT_LAYER, i_layer_req with i_layer equal to the expected layer SHALL move the FSM to ISSUE with node=0 and word=0.
REQ-010 In WAIT_LAYER, i_layer_req with a mismatched i_layer SHALL set o_error and move the FSM to IDLE.
REQ-011 In ISSUE, o_mem_rd_en SHALL be 1 every cycle with word incrementing, and after word=Fk the FSM SHALL move to WAIT_NODE, so exactly Fk+1 back-to-back reads are made per node.
REQ-012 o_weight_valid SHALL be o_mem_rd_en delayed by 1 cycle, and o_weight SHALL equal i_mem_data in that cycle.
REQ-013 In WAIT_NODE, i_node_done SHALL increment node.
- If node was the last node of a layer below 3: expected layer increments and the FSM goes to WAIT_LAYER.
- If node was the last node of layer 3: the FSM goes to DONE.
- Otherwise: the FSM returns to ISSUE with word=0.
REQ-014 i_node_done outside WAIT_NODE SHALL be ignored.
REQ-015 DONE SHALL last one cycle, assert o_done for that cycle, and then go to IDLE; i_start in DONE SHALL be ignored.
REQ-016 o_busy SHALL be 1 in every state except IDLE.
REQ-017 i_abort in any state SHALL force IDLE on the next edge, clear the counters and deassert o_mem_rd_en.
REQ-018 i_abort SHALL suppress the o_weight_valid of any read in flight.
REQ-019 i_abort SHALL take priority over every simultaneous input.
REQ-020 o_error SHALL clear only on reset or on an accepted i_start.

Reset
REQ-021 While rst=1, the FSM SHALL be in IDLE and all counters SHALL be 0.
REQ-022 While rst=1, o_mem_rd_en, o_weight_valid, o_busy, o_done and o_error SHALL be 0, and o_mem_addr and o_weight SHALL be 0.
REQ-023 Reset mid-pass SHALL take effect asynchronously, with no residual o_weight_valid after rst deasserts.

Verification
REQ-024 The bench SHALL cover these scenarios, at default parameters:
- Full pass: i_start, then layer_req 1/2/3 in order with i_node_done after each node gives 1251 o_weight_valid beats, addresses 0..1250 in order, and o_done one cycle after the last i_node_done.
- Per-node framing: layer 1, node 0 gives addresses 0,1,2 on consecutive cycles, then o_mem_rd_en stays 0 until i_node_done; node 1 then starts at address 3.
- Layer boundary: the first layer-2 read is at address 96 and the first layer-3 read is at address 1152.
- Sequence error: in WAIT_LAYER with expected layer 1, i_layer_req with i_layer=2 gives o_error=1, o_busy=0 and no reads; a new i_start clears o_error.
- Abort: i_abort on the cycle after the read of address 50 gives no o_weight_valid for that read, the next cycle shows o_busy=0, and a following i_start restarts at address 0.
- Reset mid-pass: rst asserted during ISSUE forces all outputs to 0 immediately.
